// File: rtl/mux8_rr_sched.sv
// rtl/mux8_rr_sched.sv - round-robin 8-lane scheduler driving a shared lane mux
// Grants one lane at a time for up to HOLD accepted beats, then idles one cycle to re-arbitrate.
module mux8_rr_sched #(
    parameter int DW   = 1,
    parameter int HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      req,
    input  logic [8*DW-1:0] din,
    output logic [7:0]      gnt,
    output logic [2:0]      sel,
    output logic [7:0]      ack,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t      state_q, state_d;
    logic [7:0]  gnt_q, gnt_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [DW-1:0] lane [8];
    logic [2:0]    win;
    logic          found;
    logic [2:0]    idx;
    logic          accept;
    logic          release_now;

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign lane[k] = din[k*DW +: DW];
    end

    // First requester at or above ptr, wrapping modulo 8.
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        out_valid   = 1'b0;
        out_data    = '0;
        ack         = 8'd0;
        accept      = 1'b0;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = win;
                    gnt_d   = 8'd1 << win;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                out_valid   = req[sel_q];
                out_data    = lane[sel_q];
                accept      = out_valid & out_ready;
                ack[sel_q]  = accept;
                if (accept) begin
                    cnt_d = cnt_q + 4'd1;
                end
                release_now = (accept && (cnt_q == HOLD_LAST)) || !req[sel_q];
                if (release_now) begin
                    state_d = IDLE;
                    gnt_d   = 8'd0;
                    ptr_d   = sel_q + 3'd1;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb/tb_mux8_rr_sched.sv - directed self-checking bench for mux8_rr_sched
module tb_mux8_rr_sched;

    localparam int DW   = 8;
    localparam int HOLD = 4;

    logic            clk;
    logic            rst;
    logic [7:0]      req;
    logic [8*DW-1:0] din;
    logic [7:0]      gnt;
    logic [2:0]      sel;
    logic [7:0]      ack;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;

    int checks = 0;
    int errors = 0;

    mux8_rr_sched #(.DW(DW), .HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .sel       (sel),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_lane(input int k, input logic [7:0] v);
        din[k*DW +: DW] = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'd0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) set_lane(k, 8'hA0 + 8'(k));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h expected 00", gnt); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL reset_ack: got %h expected 00", ack); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
        checks++; if (dut.ptr_q !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q); end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h08;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b expected 0", out_valid); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); #1;
            checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL single_gnt beat %0d: got %h expected 08", b, gnt); end
            checks++; if (sel !== 3'd3) begin errors++; $display("FAIL single_sel beat %0d: got %0d expected 3", b, sel); end
            checks++; if (ack !== 8'h08) begin errors++; $display("FAIL single_ack beat %0d: got %h expected 08", b, ack); end
            checks++; if (out_data !== 8'hA3) begin errors++; $display("FAIL single_data beat %0d: got %h expected a3", b, out_data); end
        end
        @(negedge clk); #1;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL single_bubble_gnt: got %h expected 00", gnt); end
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL single_bubble_ack: got %h expected 00", ack); end
        checks++; if (dut.ptr_q !== 3'd4) begin errors++; $display("FAIL single_ptr: got %0d expected 4", dut.ptr_q); end
        @(negedge clk); #1;
        checks++; if (gnt !== 8'h08) begin errors++; $display("FAIL single_regrant: got %h expected 08", gnt); end
        req = 8'h00;
    endtask

    task automatic test_round_robin();
        logic [2:0] lane_exp;
        do_reset();
        req = 8'hFF;
        out_ready = 1'b1;
        for (int g = 0; g < 9; g++) begin
            lane_exp = 3'(g % 8);
            for (int b = 0; b < 4; b++) begin
                @(negedge clk); #1;
                checks++; if (sel !== lane_exp) begin errors++; $display("FAIL rr_sel grant %0d beat %0d: got %0d expected %0d", g, b, sel, lane_exp); end
                checks++; if (ack !== (8'd1 << lane_exp)) begin errors++; $display("FAIL rr_ack grant %0d beat %0d: got %h expected %h", g, b, ack, 8'd1 << lane_exp); end
            end
            @(negedge clk); #1;
            checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL rr_bubble grant %0d: got %h expected 00", g, gnt); end
        end
        req = 8'h00;
    endtask

    task automatic test_pointer_skip();
        do_reset();
        req = 8'h20;
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) @(negedge clk);
        @(negedge clk); #1;
        checks++; if (dut.ptr_q !== 3'd6) begin errors++; $display("FAIL skip_ptr: got %0d expected 6", dut.ptr_q); end
        req = 8'h21;
        @(negedge clk); #1;
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL skip_first: got %h expected 01", gnt); end
        for (int b = 0; b < 4; b++) @(negedge clk);
        @(negedge clk); #1;
        checks++; if (gnt !== 8'h20) begin errors++; $display("FAIL skip_second: got %h expected 20", gnt); end
        req = 8'h00;
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h04;
        out_ready = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid stall %0d: got %b expected 1", s, out_valid); end
            checks++; if (ack !== 8'h00) begin errors++; $display("FAIL bp_ack stall %0d: got %h expected 00", s, ack); end
            checks++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL bp_cnt stall %0d: got %0d expected 0", s, dut.cnt_q); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            set_lane(2, 8'h50 + 8'(b));
            #1;
            checks++; if (ack !== 8'h04) begin errors++; $display("FAIL bp_beat_ack %0d: got %h expected 04", b, ack); end
            checks++; if (out_data !== 8'h50 + 8'(b)) begin errors++; $display("FAIL bp_beat_data %0d: got %h expected %h", b, out_data, 8'h50 + 8'(b)); end
            @(negedge clk);
        end
        #1;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL bp_release: got %h expected 00", gnt); end
        req = 8'h00;
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 8'h40;
        out_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (ack !== 8'h40) begin errors++; $display("FAIL drop_ack0: got %h expected 40", ack); end
        @(negedge clk); #1;
        checks++; if (dut.cnt_q !== 4'd1) begin errors++; $display("FAIL drop_cnt1: got %0d expected 1", dut.cnt_q); end
        @(negedge clk);
        req = 8'h00;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b expected 0", out_valid); end
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL drop_ack: got %h expected 00", ack); end
        @(negedge clk); #1;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL drop_gnt: got %h expected 00", gnt); end
        checks++; if (dut.cnt_q !== 4'd0) begin errors++; $display("FAIL drop_cnt: got %0d expected 0", dut.cnt_q); end
        checks++; if (dut.ptr_q !== 3'd7) begin errors++; $display("FAIL drop_ptr: got %0d expected 7", dut.ptr_q); end
        checks++; if (sel !== 3'd6) begin errors++; $display("FAIL drop_sel_hold: got %0d expected 6", sel); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h10;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (ack !== 8'h10) begin errors++; $display("FAIL midrst_beat2: got %h expected 10", ack); end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (gnt !== 8'h00) begin errors++; $display("FAIL midrst_gnt: got %h expected 00", gnt); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL midrst_sel: got %0d expected 0", sel); end
        checks++; if (dut.ptr_q !== 3'd0) begin errors++; $display("FAIL midrst_ptr: got %0d expected 0", dut.ptr_q); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        rst = 1'b0;
        req = 8'h11;
        @(negedge clk); #1;
        checks++; if (gnt !== 8'h01) begin errors++; $display("FAIL midrst_regrant: got %h expected 01", gnt); end
        req = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        req = 8'd0;
        din = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_skip();
        test_backpressure();
        test_early_drop();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
